// File: rtl/ifetch.sv
// Instruction fetch: one outstanding imem request feeding a DEPTH-entry instruction FIFO.
// Latency: handshake -> imem_req next cycle; imem_ack -> inst_valid next cycle (1 instr/cycle sustained).
// Backpressure: fetch_pc_ready drops when the FIFO could not absorb the outstanding request.
//
// Ports:
//   clk, clr_n                       clock, async active-low reset
//   fetch_pc/_valid/_ready           fetch target handshake from the pc block
//   imem_req/addr, imem_ack/rdata    instruction memory request / response
//   flush                            redirect: drop buffered and in-flight instructions
//   inst_valid/inst/inst_pc/ready    buffer head towards decode
//   fetch_err                        sticky watchdog flag
// Optional feature: define IFETCH_TIMEOUT_EN to enable the 255-cycle fetch watchdog.
module ifetch #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        clr_n,
  input  logic [31:0] fetch_pc,
  input  logic        fetch_pc_valid,
  output logic        fetch_pc_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        flush,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready,
  output logic        fetch_err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, REQ, DROP} state_t;

  state_t          state_q;
  logic [31:0]     addr_q;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     cnt_q, cnt_d;
  logic [31:0]     mem_inst [DEPTH];
  logic [31:0]     mem_pc   [DEPTH];
  logic            push, pop, hs, tmo_hit;

  assign push = (state_q == REQ) & imem_ack & ~flush;
  assign pop  = inst_valid & inst_ready & ~flush;
  assign cnt_d = cnt_q + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};

  // Accept a new target only if the FIFO will still have a free slot for it
  // once this cycle's push/pop settle; that slot is reserved for its ack.
  // clr_n gating keeps ready low while reset is held.
  assign fetch_pc_ready = clr_n & ~flush
                        & ((state_q == IDLE) | ((state_q == REQ) & imem_ack))
                        & (cnt_d < FULL);
  assign hs = fetch_pc_valid & fetch_pc_ready;

  assign imem_req  = (state_q != IDLE);
  assign imem_addr = addr_q;

`ifdef IFETCH_TIMEOUT_EN
  logic [7:0] tmo_q;
  logic       err_q;

  // Fires on the 255th consecutive waiting cycle.
  assign tmo_hit = (state_q != IDLE) & ~imem_ack & (tmo_q == 8'd254);

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      tmo_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      if ((state_q != IDLE) && !imem_ack)
        tmo_q <= tmo_hit ? 8'd0 : tmo_q + 8'd1;
      else
        tmo_q <= 8'd0;
      if (tmo_hit)
        err_q <= 1'b1;
    end
  end

  assign fetch_err = err_q;
`else
  assign tmo_hit   = 1'b0;
  assign fetch_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hs) begin
            state_q <= REQ;
            addr_q  <= fetch_pc;
          end
        end
        REQ: begin
          // hs cannot be set together with flush, so ack+flush lands in IDLE.
          if (imem_ack) begin
            if (hs) addr_q  <= fetch_pc;
            else    state_q <= IDLE;
          end else if (flush) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          if (imem_ack) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
      if (tmo_hit) state_q <= IDLE;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_inst[wr_ptr_q] <= imem_rdata;
      mem_pc[wr_ptr_q]   <= addr_q;
    end
  end

  assign inst_valid = (cnt_q != '0);
  assign inst       = inst_valid ? mem_inst[rd_ptr_q] : 32'h0;
  assign inst_pc    = inst_valid ? mem_pc[rd_ptr_q]   : 32'h0;

endmodule

// File: tb/tb_ifetch.sv
module tb_ifetch;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        clr_n;
  logic [31:0] fetch_pc;
  logic        fetch_pc_valid;
  logic        fetch_pc_ready;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        flush;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;
  logic        fetch_err;

  ifetch #(.DEPTH(DEPTH)) dut (
    .clk(clk), .clr_n(clr_n),
    .fetch_pc(fetch_pc), .fetch_pc_valid(fetch_pc_valid), .fetch_pc_ready(fetch_pc_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .flush(flush),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready),
    .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: a queue of fetched (pc, word) pairs, plus whether a
  // request is in flight and whether its data is to be thrown away.
  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  ent_t        q[$];
  bit          m_out, m_drop, m_err, m_hs;
  logic [31:0] m_addr;
  int          m_wait;

  task automatic model_reset();
    q.delete();
    m_out = 0; m_drop = 0; m_err = 0; m_hs = 0; m_addr = 32'h0; m_wait = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr_n = 1'b0;
    fetch_pc_valid = 1'b1; fetch_pc = 32'h44; flush = 1'b0;
    imem_ack = 1'b0; inst_ready = 1'b1; imem_rdata = 32'h0;
    #1;
    check("rst imem_req",   imem_req, 0);
    check("rst imem_addr",  imem_addr, 0);
    check("rst ready",      fetch_pc_ready, 0);
    check("rst inst_valid", inst_valid, 0);
    check("rst inst",       inst, 0);
    check("rst inst_pc",    inst_pc, 0);
    check("rst fetch_err",  fetch_err, 0);
    model_reset();
    @(negedge clk);
    clr_n = 1'b1;
    fetch_pc_valid = 1'b0;
  endtask

  // One clock cycle: drive inputs, check outputs against the model, advance the model.
  task automatic step(input bit v, input logic [31:0] pc, input bit ack,
                      input logic [31:0] rd, input bit fl, input bit ir);
    bit   pop, push, rdy, tmo;
    int   after;
    ent_t e;
    @(negedge clk);
    fetch_pc_valid = v; fetch_pc = pc; imem_ack = ack; imem_rdata = rd;
    flush = fl; inst_ready = ir;
    pop   = (q.size() > 0) && ir && !fl;
    push  = m_out && !m_drop && ack && !fl;
    after = q.size() + int'(push) - int'(pop);
    rdy   = !fl && (!m_out || (!m_drop && ack)) && (after < DEPTH);
    #1;
    check("imem_req", imem_req, m_out);
    if (m_out) check("imem_addr", imem_addr, m_addr);
    check("inst_valid", inst_valid, q.size() > 0);
    check("inst",    inst,    q.size() > 0 ? q[0].ins : 32'h0);
    check("inst_pc", inst_pc, q.size() > 0 ? q[0].pc  : 32'h0);
    check("fetch_pc_ready", fetch_pc_ready, rdy);
    check("fetch_err", fetch_err, m_err);
    m_hs = v && rdy;
    if (fl) q.delete();
    else begin
      if (pop) void'(q.pop_front());
      if (push) begin e.pc = m_addr; e.ins = rd; q.push_back(e); end
    end
    tmo = 0;
`ifdef IFETCH_TIMEOUT_EN
    if (m_out && !ack) begin
      m_wait++;
      if (m_wait == 255) tmo = 1;
    end else m_wait = 0;
`endif
    if (!m_out) begin
      if (m_hs) begin m_out = 1; m_addr = pc; end
    end else if (m_drop) begin
      if (ack) begin m_out = 0; m_drop = 0; end
    end else if (ack) begin
      m_out = m_hs;
      if (m_hs) m_addr = pc;
    end else if (fl) m_drop = 1;
    if (tmo) begin m_out = 0; m_drop = 0; m_err = 1; m_wait = 0; end
  endtask

  initial begin
    logic [31:0] a;
    clr_n = 1'b0; fetch_pc = 0; fetch_pc_valid = 0; imem_ack = 0;
    imem_rdata = 0; flush = 0; inst_ready = 0;
    model_reset();
    do_reset();

    // Single fetch at 0x10, ack one cycle late.
    step(1, 32'h10, 0, 32'h0, 0, 0);
    step(0, 32'h0, 0, 32'h0, 0, 0);
    step(0, 32'h0, 1, 32'hDEADBEEF, 0, 0);
    step(0, 32'h0, 0, 32'h0, 0, 1);
    check("single inst_pc_seen", q.size(), 0);
    step(0, 32'h0, 0, 32'h0, 0, 0);

    // Streaming 0..3 with ack every cycle and decode always ready.
    for (int i = 0; i < 7; i++)
      step(i < 4, i, i > 0 && i < 5, 32'h1000_0000 + i, 0, 1);

    // Decode stalled: buffer fills, no further request, one pop restarts fetch.
    a = 0;
    for (int i = 0; i < 6; i++) begin
      step(1, a, 1, 32'h2000_0000 + i, 0, 0);
      if (m_hs) a++;
    end
    for (int i = 0; i < 4; i++) begin
      step(1, a, 1, 32'h3000_0000 + i, 0, i == 0);
      if (m_hs) a++;
    end
    for (int i = 0; i < 6; i++) step(0, 0, 1, 32'h0, 0, 1);

    // Flush with request outstanding at 0x20, ack three cycles later.
    do_reset();
    step(1, 32'h20, 0, 32'h0, 0, 0);
    step(1, 32'h40, 0, 32'h0, 1, 0);
    step(1, 32'h40, 0, 32'h0, 0, 0);
    step(1, 32'h40, 0, 32'h0, 0, 0);
    step(1, 32'h40, 1, 32'hBAD0BAD0, 0, 0);
    step(1, 32'h40, 0, 32'h0, 0, 0);
    step(0, 32'h0, 1, 32'h4040_4040, 0, 0);
    step(0, 32'h0, 0, 32'h0, 0, 1);

    // Reset mid-request; a late ack afterwards must be ignored.
    step(1, 32'h50, 0, 32'h0, 0, 0);
    do_reset();
    step(0, 32'h0, 1, 32'h5555_5555, 0, 1);
    step(0, 32'h0, 0, 32'h0, 0, 1);

    // Randomised traffic with occasional flushes, stalls, spurious acks and resets.
    for (int i = 0; i < 3000; i++) begin
      if (i % 997 == 500) do_reset();
      step(($urandom % 4) != 0, $urandom, m_out ? (($urandom % 3) != 0) : (($urandom % 16) == 0),
           $urandom, ($urandom % 16) == 0, ($urandom % 2) == 0);
    end

`ifdef IFETCH_TIMEOUT_EN
    // Request that never completes trips the watchdog; reset clears the flag.
    do_reset();
    step(1, 32'h80, 0, 32'h0, 0, 0);
    for (int i = 0; i < 260; i++) step(0, 32'h0, 0, 32'h0, 0, 0);
    check("tmo fetch_err", fetch_err, 1);
    check("tmo imem_req", imem_req, 0);
    do_reset();
    step(0, 32'h0, 0, 32'h0, 0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
